// File: rtl/toy_eu_fwd_tracker_if.sv
// ---------------------------------------------------------------------------
// toy_eu_fwd_tracker_if
//
// Bundles the issue-stage signals of the forwarding tracker.
//   master : issue logic (drives producer/consumer requests, flush)
//   slave  : the tracker (drives slot availability and forward controls)
//
// Producer side : cancel_en, prod_en, prod_rd, prod_lat -> slot_free
// Consumer side : cons_en, cons_rs, cons_rs_vld -> fwd_cycle, fwd_id, rs_busy
// Status        : inflight_cnt, lat_err
//
// Handshake semantics: there is no backpressure. A request is taken in the
// cycle its enable (prod_en[e] / cons_en) is high. The consumer response is
// combinational in that same cycle. A producer request is accepted at the
// next clock edge only if slot_free allowed it; otherwise it is dropped and
// lat_err latches.
// ---------------------------------------------------------------------------
interface toy_eu_fwd_tracker_if #(
  parameter int EU_NUM  = 4,
  parameter int PREG_W  = 7,
  parameter int MAX_LAT = 4,
  parameter int RS_NUM  = 3
);
  localparam int ID_W  = (EU_NUM > 1) ? $clog2(EU_NUM) : 1;
  localparam int CNT_W = $clog2(EU_NUM * MAX_LAT) + 1;

  logic                                 cancel_en;
  logic [EU_NUM-1:0]                    prod_en;
  logic [EU_NUM-1:0][PREG_W-1:0]        prod_rd;
  logic [EU_NUM-1:0][1:0]               prod_lat;
  logic [EU_NUM-1:0][MAX_LAT-1:0]       slot_free;
  logic                                 cons_en;
  logic [RS_NUM-1:0][PREG_W-1:0]        cons_rs;
  logic [RS_NUM-1:0]                    cons_rs_vld;
  logic [RS_NUM-1:0][1:0]               fwd_cycle;
  logic [RS_NUM-1:0][ID_W-1:0]          fwd_id;
  logic [RS_NUM-1:0]                    rs_busy;
  logic [CNT_W-1:0]                     inflight_cnt;
  logic                                 lat_err;

  modport master (
    output cancel_en, prod_en, prod_rd, prod_lat,
    output cons_en, cons_rs, cons_rs_vld,
    input  slot_free, fwd_cycle, fwd_id, rs_busy, inflight_cnt, lat_err
  );

  modport slave (
    input  cancel_en, prod_en, prod_rd, prod_lat,
    input  cons_en, cons_rs, cons_rs_vld,
    output slot_free, fwd_cycle, fwd_id, rs_busy, inflight_cnt, lat_err
  );
endinterface

// File: rtl/toy_eu_fwd_tracker.sv
// ---------------------------------------------------------------------------
// toy_eu_fwd_tracker
//
// Tracks in-flight execution-unit results between issue and writeback and
// schedules the operand forwarding network.
//
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : toy_eu_fwd_tracker_if.slave
//          - prod_*    : per-EU producer issue (destination reg, latency-1)
//          - slot_free : per-EU writeback-slot availability, [e][L-1]
//          - cons_*    : consumer source lookup query
//          - fwd_cycle/fwd_id/rs_busy : per-source forward control
//          - inflight_cnt : registered count of valid slots
//          - lat_err   : sticky illegal-latency / collision flag
//
// State: per EU, a MAX_LAT-deep slot array {valid, rd}. Slot k valid means
// the result for rd appears on that EU's forward lane k cycles from now.
// The array shifts down by one each edge; slot 0 retires.
// ---------------------------------------------------------------------------
module toy_eu_fwd_tracker #(
  parameter int EU_NUM  = 4,
  parameter int PREG_W  = 7,
  parameter int MAX_LAT = 4,
  parameter int RS_NUM  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  toy_eu_fwd_tracker_if.slave  bus
);

  localparam int ID_W  = (EU_NUM > 1) ? $clog2(EU_NUM) : 1;
  localparam int CNT_W = $clog2(EU_NUM * MAX_LAT) + 1;

  // Slot state
  logic [EU_NUM-1:0][MAX_LAT-1:0]             slot_vld_q, slot_vld_d;
  logic [EU_NUM-1:0][MAX_LAT-1:0][PREG_W-1:0] slot_rd_q,  slot_rd_d;
  logic [CNT_W-1:0]                           cnt_q,      cnt_d;
  logic                                       err_q,      err_d;

  // Combinational outputs
  logic [EU_NUM-1:0][MAX_LAT-1:0]             slot_free_c;
  logic [RS_NUM-1:0][1:0]                     fwd_cycle_c;
  logic [RS_NUM-1:0][ID_W-1:0]                fwd_id_c;
  logic [RS_NUM-1:0]                          rs_busy_c;

  // -------------------------------------------------------------------------
  // Slot availability. Issuing with latency L lands in slot L-1 after the
  // shift, which is where slot L currently sits. So latency L is free when
  // slot L is empty. The deepest latency always lands in the slot that is
  // vacated by the shift, so it is always free.
  // -------------------------------------------------------------------------
  always_comb begin
    slot_free_c = '0;
    for (int e = 0; e < EU_NUM; e++) begin
      for (int j = 0; j < MAX_LAT; j++) begin
        if (j < MAX_LAT - 1) begin
          slot_free_c[e][j] = !slot_vld_q[e][j+1];
        end else begin
          slot_free_c[e][j] = 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state: shift, then insert accepted producers, then count.
  // -------------------------------------------------------------------------
  always_comb begin
    int   lat;
    logic free;
    slot_vld_d = '0;
    slot_rd_d  = '0;
    err_d      = err_q;
    cnt_d      = '0;
    lat        = 0;
    free       = 1'b0;

    for (int e = 0; e < EU_NUM; e++) begin
      // Shift toward slot 0; the top slot empties.
      for (int k = 0; k < MAX_LAT - 1; k++) begin
        slot_vld_d[e][k] = slot_vld_q[e][k+1];
        slot_rd_d[e][k]  = slot_rd_q[e][k+1];
      end

      if (bus.prod_en[e] && !bus.cancel_en) begin
        lat  = int'(bus.prod_lat[e]) + 1;
        free = 1'b0;
        for (int k = 0; k < MAX_LAT; k++) begin
          if (k == lat - 1) begin
            free = slot_free_c[e][k];
          end
        end
        if ((lat <= MAX_LAT) && free) begin
          for (int k = 0; k < MAX_LAT; k++) begin
            if (k == lat - 1) begin
              slot_vld_d[e][k] = 1'b1;
              slot_rd_d[e][k]  = bus.prod_rd[e];
            end
          end
        end else begin
          // The request is dropped, and the existing entries stay as shifted.
          err_d = 1'b1;
        end
      end
    end

    // A flush wipes every slot. Lookups this cycle still see the old state.
    if (bus.cancel_en) begin
      slot_vld_d = '0;
    end

    for (int e = 0; e < EU_NUM; e++) begin
      for (int k = 0; k < MAX_LAT; k++) begin
        cnt_d = cnt_d + CNT_W'(slot_vld_d[e][k]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld_q <= '0;
      slot_rd_q  <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      slot_vld_q <= slot_vld_d;
      slot_rd_q  <= slot_rd_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Consumer lookup. The first EU (lowest index) with any match decides the
  // source. Inside that EU, next-cycle data (slot 1 or a same-cycle L=1 issue)
  // beats this-cycle data (slot 0). A match further out only marks the source
  // busy. fwd_id reports the matching EU in every match case.
  // -------------------------------------------------------------------------
  always_comb begin
    logic hit;
    logic m0;
    logic m1;
    logic mb;
    fwd_cycle_c = '0;
    fwd_id_c    = '0;
    rs_busy_c   = '0;
    hit         = 1'b0;
    m0          = 1'b0;
    m1          = 1'b0;
    mb          = 1'b0;

    for (int i = 0; i < RS_NUM; i++) begin
      hit = 1'b0;
      if (bus.cons_en && bus.cons_rs_vld[i]) begin
        for (int e = 0; e < EU_NUM; e++) begin
          m0 = slot_vld_q[e][0] && (slot_rd_q[e][0] == bus.cons_rs[i]);
          m1 = (slot_vld_q[e][1] && (slot_rd_q[e][1] == bus.cons_rs[i])) ||
               (bus.prod_en[e] && (bus.prod_lat[e] == 2'd0) &&
                (bus.prod_rd[e] == bus.cons_rs[i]));
          mb = bus.prod_en[e] && (bus.prod_lat[e] != 2'd0) &&
               (bus.prod_rd[e] == bus.cons_rs[i]);
          for (int k = 2; k < MAX_LAT; k++) begin
            mb = mb || (slot_vld_q[e][k] && (slot_rd_q[e][k] == bus.cons_rs[i]));
          end

          if (!hit && (m0 || m1 || mb)) begin
            hit         = 1'b1;
            fwd_id_c[i] = ID_W'(e);
            if (m1) begin
              fwd_cycle_c[i] = 2'b10;
            end else if (m0) begin
              fwd_cycle_c[i] = 2'b01;
            end else begin
              rs_busy_c[i] = 1'b1;
            end
          end
        end
      end
    end
  end

  assign bus.slot_free    = slot_free_c;
  assign bus.fwd_cycle    = fwd_cycle_c;
  assign bus.fwd_id       = fwd_id_c;
  assign bus.rs_busy      = rs_busy_c;
  assign bus.inflight_cnt = cnt_q;
  assign bus.lat_err      = err_q;

endmodule

// File: tb/tb_toy_eu_fwd_tracker.sv
module tb_toy_eu_fwd_tracker;

  localparam int EU_NUM  = 4;
  localparam int PREG_W  = 7;
  localparam int MAX_LAT = 4;
  localparam int RS_NUM  = 3;
  localparam int W       = 40;

  // Expectation kinds
  localparam int K_FC   = 0;
  localparam int K_ID   = 1;
  localparam int K_BUSY = 2;
  localparam int K_SF   = 3;
  localparam int K_CNT  = 4;
  localparam int K_ERR  = 5;

  logic clk;
  logic rst;

  toy_eu_fwd_tracker_if #(
    .EU_NUM(EU_NUM), .PREG_W(PREG_W), .MAX_LAT(MAX_LAT), .RS_NUM(RS_NUM)
  ) bus ();

  toy_eu_fwd_tracker #(
    .EU_NUM(EU_NUM), .PREG_W(PREG_W), .MAX_LAT(MAX_LAT), .RS_NUM(RS_NUM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required end");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;

  task automatic expect_val(input int kind, input int idx, input logic [31:0] v);
    exp_q.push_back({4'(kind), 4'(idx), v});
  endtask

  function automatic string kind_name(input int kind);
    case (kind)
      K_FC:    return "fwd_cycle";
      K_ID:    return "fwd_id";
      K_BUSY:  return "rs_busy";
      K_SF:    return "slot_free";
      K_CNT:   return "inflight_cnt";
      default: return "lat_err";
    endcase
  endfunction

  function automatic logic [31:0] actual(input int kind, input int idx);
    logic [31:0] a;
    a = '0;
    case (kind)
      K_FC:    a[1:0]  = bus.fwd_cycle[idx];
      K_ID:    a[1:0]  = bus.fwd_id[idx];
      K_BUSY:  a[0]    = bus.rs_busy[idx];
      K_SF:    a[15:0] = bus.slot_free;
      K_CNT:   a[4:0]  = bus.inflight_cnt;
      default: a[0]    = bus.lat_err;
    endcase
    return a;
  endfunction

  // Monitor: outputs are settled by the falling edge; drain everything the
  // driver queued for this cycle.
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [31:0]  act;
    int           kind;
    int           idx;
    while (exp_q.size() > 0) begin
      e    = exp_q.pop_front();
      kind = int'(e[39:36]);
      idx  = int'(e[35:32]);
      act  = actual(kind, idx);
      n_checks++;
      if (act !== e[31:0]) begin
        n_err++;
        $display("FAIL %s[%0d] @%0t: got %0h expected %0h",
                 kind_name(kind), idx, $time, act, e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.cancel_en   = 1'b0;
    bus.prod_en     = '0;
    bus.prod_rd     = '0;
    bus.prod_lat    = '0;
    bus.cons_en     = 1'b0;
    bus.cons_rs     = '0;
    bus.cons_rs_vld = '0;
  endtask

  task automatic issue(input int e, input int rd, input int lat_m1);
    bus.prod_en[e]  = 1'b1;
    bus.prod_rd[e]  = PREG_W'(rd);
    bus.prod_lat[e] = 2'(lat_m1);
  endtask

  task automatic query(input int i, input int rs);
    bus.cons_en        = 1'b1;
    bus.cons_rs[i]     = PREG_W'(rs);
    bus.cons_rs_vld[i] = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    expect_val(K_SF, 0, 32'hFFFF);
    expect_val(K_CNT, 0, 0);
    expect_val(K_ERR, 0, 0);
    expect_val(K_FC, 0, 0);
    expect_val(K_BUSY, 0, 0);
    expect_val(K_ID, 0, 0);
    tick();

    // EU1 rd=5 L=3, consumer follows it to the lane
    issue(1, 5, 2);
    query(0, 5);
    expect_val(K_BUSY, 0, 1);               // same-cycle issue, L>=2
    expect_val(K_FC, 0, 0);
    tick();
    bus.prod_en = '0;
    expect_val(K_BUSY, 0, 1);               // slot 2
    expect_val(K_FC, 0, 0);
    expect_val(K_SF, 0, 32'hFFDF);          // EU1 latency 2 blocked
    expect_val(K_CNT, 0, 1);
    tick();
    expect_val(K_FC, 0, 2);                 // slot 1
    expect_val(K_ID, 0, 1);
    expect_val(K_BUSY, 0, 0);
    expect_val(K_SF, 0, 32'hFFEF);          // EU1 latency 1 blocked
    tick();
    expect_val(K_FC, 0, 1);                 // slot 0
    expect_val(K_ID, 0, 1);
    expect_val(K_SF, 0, 32'hFFFF);
    expect_val(K_CNT, 0, 1);
    tick();
    expect_val(K_CNT, 0, 0);
    expect_val(K_FC, 0, 0);
    tick();

    // EU2 rd=9 L=1 with same-cycle consumer on rs2
    clear_inputs();
    issue(2, 9, 0);
    query(1, 9);
    bus.cons_rs[0] = 7'd5;
    expect_val(K_FC, 1, 2);
    expect_val(K_ID, 1, 2);
    expect_val(K_BUSY, 1, 0);
    expect_val(K_FC, 0, 0);
    tick();
    bus.prod_en = '0;
    expect_val(K_FC, 1, 1);
    expect_val(K_ID, 1, 2);
    expect_val(K_CNT, 0, 1);
    expect_val(K_SF, 0, 32'hFFFF);
    tick();
    expect_val(K_CNT, 0, 0);
    expect_val(K_FC, 1, 0);
    tick();

    // EU0 L=3 then L=2 colliding on the same arrival cycle
    clear_inputs();
    issue(0, 11, 2);
    expect_val(K_ERR, 0, 0);
    tick();
    issue(0, 12, 1);
    expect_val(K_SF, 0, 32'hFFFD);
    expect_val(K_ERR, 0, 0);
    tick();
    bus.prod_en = '0;
    query(0, 11);
    query(1, 12);
    expect_val(K_ERR, 0, 1);
    expect_val(K_FC, 0, 2);
    expect_val(K_ID, 0, 0);
    expect_val(K_FC, 1, 0);
    expect_val(K_BUSY, 1, 0);
    expect_val(K_CNT, 0, 1);
    tick();
    expect_val(K_FC, 0, 1);                 // first rd still intact
    tick();
    expect_val(K_CNT, 0, 0);
    tick();

    // Fill every EU at L=4 for four cycles
    clear_inputs();
    for (int c = 0; c < 4; c++) begin
      for (int e = 0; e < EU_NUM; e++) begin
        issue(e, 40 + 4 * c + e, 3);
      end
      expect_val(K_CNT, 0, 32'(4 * c));
      tick();
    end
    // Cancel cycle: lookups see pre-cancel state, prod_en is dropped
    bus.prod_en  = '0;
    issue(0, 30, 0);
    bus.cancel_en = 1'b1;
    query(0, 40);
    query(1, 45);
    query(2, 51);
    expect_val(K_CNT, 0, 16);
    expect_val(K_SF, 0, 32'h8888);
    expect_val(K_ERR, 0, 1);
    expect_val(K_FC, 0, 1);
    expect_val(K_ID, 0, 0);
    expect_val(K_FC, 1, 2);
    expect_val(K_ID, 1, 1);
    expect_val(K_BUSY, 2, 1);
    expect_val(K_FC, 2, 0);
    expect_val(K_ID, 2, 3);
    tick();
    clear_inputs();
    query(0, 30);
    expect_val(K_CNT, 0, 0);
    expect_val(K_SF, 0, 32'hFFFF);
    expect_val(K_FC, 0, 0);
    expect_val(K_BUSY, 0, 0);
    tick();

    // Reset mid-operation with valid slots and lat_err set
    clear_inputs();
    issue(3, 60, 3);
    tick();
    for (int e = 0; e < EU_NUM; e++) begin
      issue(e, 60, 0);
    end
    bus.cancel_en = 1'b1;
    rst = 1'b1;
    expect_val(K_CNT, 0, 1);
    expect_val(K_ERR, 0, 1);
    tick();
    rst = 1'b0;
    clear_inputs();
    query(0, 60);
    expect_val(K_CNT, 0, 0);
    expect_val(K_ERR, 0, 0);
    expect_val(K_SF, 0, 32'hFFFF);
    expect_val(K_FC, 0, 0);
    expect_val(K_BUSY, 0, 0);
    expect_val(K_ID, 0, 0);
    tick();

    // No producer, and a matching source that is not used
    clear_inputs();
    query(0, 20);
    expect_val(K_FC, 0, 0);
    expect_val(K_BUSY, 0, 0);
    tick();
    clear_inputs();
    issue(1, 20, 0);
    query(0, 21);
    bus.cons_rs[2] = 7'd20;                 // valid bit left low
    expect_val(K_FC, 0, 0);
    expect_val(K_BUSY, 0, 0);
    expect_val(K_FC, 2, 0);
    expect_val(K_BUSY, 2, 0);
    expect_val(K_ID, 2, 0);
    tick();
    clear_inputs();
    bus.cons_rs = {7'd20, 7'd20, 7'd20};
    bus.cons_rs_vld = 3'b111;               // cons_en low gates the lookup
    expect_val(K_FC, 0, 0);
    expect_val(K_FC, 1, 0);
    expect_val(K_CNT, 0, 1);
    tick();

    clear_inputs();
    repeat (3) tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
